// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: counter encodings, default
// table geometry and the PC index/tag slice helpers.
package branch_predictor_pkg;

  // 2-bit saturating counter states; MSB is the taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam int unsigned DEFAULT_INDEX_BITS = 6;

  // Table index: PC[index_bits+1:2], returned zero-extended to 32 bits.
  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int unsigned index_bits);
    return (pc >> 2) & ((32'd1 << index_bits) - 32'd1);
  endfunction

  // Tag: PC[31:index_bits+2], returned right-aligned in 32 bits.
  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int unsigned index_bits);
    return pc >> (index_bits + 2);
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter, one per BHT entry. Resets to weakly
// not-taken.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  output logic [1:0] cnt
);

  ctr_e cnt_q, cnt_d;

  // Next state: step toward the outcome, holding at either end.
  always_comb begin
    cnt_d = cnt_q;
    if (up && (cnt_q != ST)) begin
      cnt_d = ctr_e'(cnt_q + 2'd1);
    end else if (!up && (cnt_q != SNT)) begin
      cnt_d = ctr_e'(cnt_q - 2'd1);
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= WNT;
    end else if (en) begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: BHT of 2-bit counters plus a tagged BTB for the
// fetch-side prediction, and misprediction detection / training on the
// execute side.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned INDEX_BITS = DEFAULT_INDEX_BITS,
  parameter int unsigned TAG_BITS   = 32 - INDEX_BITS - 2,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      PCF,
  output logic             PredTakenF,
  output logic [31:0]      PredPCF,
  input  logic             IsBranchE,
  input  logic             StallE,
  input  logic             BranchE,
  input  logic [31:0]      PCE,
  input  logic [31:0]      PCPlus4E,
  input  logic [31:0]      PCTargetE,
  input  logic             PredTakenE,
  input  logic [31:0]      PredPCE,
  output logic             MispredictE,
  output logic [31:0]      PCCorrectE,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MispredictCount
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;

  logic [INDEX_BITS-1:0]       idx_f, idx_e;
  logic [TAG_BITS-1:0]         tag_f, tag_e;
  logic [ENTRIES-1:0][1:0]     ctr;
  logic [ENTRIES-1:0]          valid_q;
  logic [TAG_BITS-1:0]         tag_q    [ENTRIES];
  logic [31:0]                 target_q [ENTRIES];
  logic                        hit_f;
  logic                        train;
  logic [CNT_W-1:0]            branch_count_q, mispredict_count_q;

  assign idx_f = INDEX_BITS'(pc_index(PCF, INDEX_BITS));
  assign tag_f = TAG_BITS'(pc_tag(PCF, INDEX_BITS));
  assign idx_e = INDEX_BITS'(pc_index(PCE, INDEX_BITS));
  assign tag_e = TAG_BITS'(pc_tag(PCE, INDEX_BITS));

  // A stalled execute stage holds its branch until the stall releases.
  assign train = IsBranchE && !StallE;

  // BHT: one saturating counter per entry, stepped only at its own index.
  for (genvar i = 0; i < ENTRIES; i++) begin : g_bht
    sat_counter2 u_ctr (
      .clk   (clk),
      .rst_n (reset),
      .en    (train && (idx_e == INDEX_BITS'(i))),
      .up    (BranchE),
      .cnt   (ctr[i])
    );
  end

  // BTB valid bits: set by taken branches, never cleared by not-taken ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (train && BranchE) begin
      valid_q[idx_e] <= 1'b1;
    end
  end

  // BTB tag/target payload; gated by reset so a write racing reset is dropped.
  always_ff @(posedge clk) begin
    if (reset && train && BranchE) begin
      tag_q[idx_e]    <= tag_e;
      target_q[idx_e] <= PCTargetE;
    end
  end

  // Fetch lookup reads registered state only, so a same-cycle train is not seen.
  always_comb begin
    hit_f      = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    PredTakenF = hit_f && ctr[idx_f][1];
    PredPCF    = PredTakenF ? target_q[idx_f] : PCF + 32'd4;
  end

  // Resolve: wrong direction, or taken to a different target than predicted.
  always_comb begin
    MispredictE = train && ((BranchE != PredTakenE) || (BranchE && (PredPCE != PCTargetE)));
    PCCorrectE  = BranchE ? PCTargetE : PCPlus4E;
  end

  // Performance counters, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (train && (branch_count_q != '1)) begin
        branch_count_q <= branch_count_q + CNT_W'(1);
      end
      if (MispredictE && (mispredict_count_q != '1)) begin
        mispredict_count_q <= mispredict_count_q + CNT_W'(1);
      end
    end
  end

  assign BranchCount     = branch_count_q;
  assign MispredictCount = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a behavioural model produces
// expected outputs into a scoreboard queue; entries are popped and compared
// against the DUT once its combinational outputs have settled.
module tb_branch_predictor;

  localparam int unsigned SIG_PTAKEN = 0;
  localparam int unsigned SIG_PPC    = 1;
  localparam int unsigned SIG_MIS    = 2;
  localparam int unsigned SIG_CORR   = 3;
  localparam int unsigned SIG_BCNT   = 4;
  localparam int unsigned SIG_MCNT   = 5;

  typedef struct {
    int unsigned sig;
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  logic        clk;
  logic        reset;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredPCF;
  logic        IsBranchE;
  logic        StallE;
  logic        BranchE;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;
  logic [31:0] PCTargetE;
  logic        PredTakenE;
  logic [31:0] PredPCE;
  logic        MispredictE;
  logic [31:0] PCCorrectE;
  logic [31:0] BranchCount;
  logic [31:0] MispredictCount;

  int unsigned errors = 0;
  int unsigned checks = 0;
  sb_item_t    sb_q[$];

  // Reference model state (64 entries, 24-bit tags).
  logic [1:0]  m_ctr   [64];
  bit          m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  logic [31:0] m_bcnt, m_mcnt;

  branch_predictor dut (
    .clk             (clk),
    .reset           (reset),
    .PCF             (PCF),
    .PredTakenF      (PredTakenF),
    .PredPCF         (PredPCF),
    .IsBranchE       (IsBranchE),
    .StallE          (StallE),
    .BranchE         (BranchE),
    .PCE             (PCE),
    .PCPlus4E        (PCPlus4E),
    .PCTargetE       (PCTargetE),
    .PredTakenE      (PredTakenE),
    .PredPCE         (PredPCE),
    .MispredictE     (MispredictE),
    .PCCorrectE      (PCCorrectE),
    .BranchCount     (BranchCount),
    .MispredictCount (MispredictCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input int unsigned sig);
    case (sig)
      SIG_PTAKEN: return {31'b0, PredTakenF};
      SIG_PPC:    return PredPCF;
      SIG_MIS:    return {31'b0, MispredictE};
      SIG_CORR:   return PCCorrectE;
      SIG_BCNT:   return BranchCount;
      default:    return MispredictCount;
    endcase
  endfunction

  task automatic push(input int unsigned sig, input string tag, input logic [31:0] exp);
    sb_item_t it;
    it.sig = sig;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic drain();
    sb_item_t it;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      check(it.tag, observe(it.sig), it.exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_ctr[i]   = 2'b01;
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
    end
    m_bcnt = '0;
    m_mcnt = '0;
  endtask

  task automatic model_pred(input logic [31:0] pc, output logic taken, output logic [31:0] npc);
    int unsigned idx;
    idx   = int'(pc[7:2]);
    taken = m_valid[idx] && (m_tag[idx] == pc[31:8]) && m_ctr[idx][1];
    npc   = taken ? m_tgt[idx] : pc + 32'd4;
  endtask

  // One execute/fetch cycle: drive, predict, compare, then let the edge train.
  task automatic cycle(input logic [31:0] pcf, input logic isb, input logic stall,
                       input logic br, input logic [31:0] pce, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ppc, input string tag);
    logic        e_tk;
    logic [31:0] e_pc;
    logic        e_mis;
    int unsigned idx;
    PCF = pcf; IsBranchE = isb; StallE = stall; BranchE = br; PCE = pce;
    PCPlus4E = pce + 32'd4; PCTargetE = tgt; PredTakenE = ptk; PredPCE = ppc;
    model_pred(pcf, e_tk, e_pc);
    e_mis = isb && !stall && ((br != ptk) || (br && (ppc != tgt)));
    push(SIG_PTAKEN, {tag, ".ptaken"}, {31'b0, e_tk});
    push(SIG_PPC, {tag, ".ppc"}, e_pc);
    push(SIG_MIS, {tag, ".mis"}, {31'b0, e_mis});
    if (e_mis) push(SIG_CORR, {tag, ".corr"}, br ? tgt : pce + 32'd4);
    push(SIG_BCNT, {tag, ".bcnt"}, m_bcnt);
    push(SIG_MCNT, {tag, ".mcnt"}, m_mcnt);
    #1;
    drain();
    if (isb && !stall && reset) begin
      idx = int'(pce[7:2]);
      if (br) begin
        if (m_ctr[idx] != 2'b11) m_ctr[idx] = m_ctr[idx] + 2'd1;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = pce[31:8];
        m_tgt[idx]   = tgt;
      end else if (m_ctr[idx] != 2'b00) begin
        m_ctr[idx] = m_ctr[idx] - 2'd1;
      end
      m_bcnt++;
      if (e_mis) m_mcnt++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Branch resolving at pc, carrying the prediction fetch would have made.
  task automatic branch(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                        input string tag);
    logic        ptk;
    logic [31:0] ppc;
    model_pred(pc, ptk, ppc);
    cycle(pc, 1'b1, 1'b0, taken, pc, tgt, ptk, ppc, tag);
  endtask

  task automatic lookup(input logic [31:0] pc, input string tag);
    cycle(pc, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, tag);
  endtask

  logic [31:0] pcs [5];

  initial begin
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h200; pcs[3] = 32'h1100; pcs[4] = 32'h3fc;
    reset = 1'b0;
    {IsBranchE, StallE, BranchE, PredTakenE} = '0;
    PCF = 32'h100; PCE = '0; PCPlus4E = '0; PCTargetE = '0; PredPCE = '0;
    model_reset();
    @(negedge clk);
    lookup(32'h100, "in_reset");
    reset = 1'b1;
    lookup(32'h100, "post_reset");
    check("post_reset_ppc_const", PredPCF, 32'h104);

    // First taken branch: mispredict with redirect to 0x80; lookup same cycle
    // must still see the untrained entry.
    cycle(32'h100, 1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h104, "first_taken");
    lookup(32'h100, "after_first");
    check("after_first_ppc_const", PredPCF, 32'h80);

    for (int i = 0; i < 4; i++) branch(32'h100, 1'b1, 32'h80, "taken_run");
    branch(32'h100, 1'b0, 32'h80, "nt_once");
    lookup(32'h100, "still_taken");
    branch(32'h100, 1'b0, 32'h80, "nt_two_a");
    branch(32'h100, 1'b0, 32'h80, "nt_two_b");
    lookup(32'h100, "now_nt");
    check("now_nt_ppc_const", PredPCF, 32'h104);

    // Aliasing: 0x100 and 0x200 share index 0.
    branch(32'h100, 1'b1, 32'h80, "alias_a");
    branch(32'h200, 1'b1, 32'h40, "alias_b");
    lookup(32'h100, "alias_miss");
    lookup(32'h200, "alias_hit");
    check("alias_hit_ppc_const", PredPCF, 32'h40);

    // Direction right, target wrong.
    cycle(32'h0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h90, 1'b1, 32'h80, "tgt_mismatch");
    check("tgt_mismatch_mcnt", MispredictCount, m_mcnt);

    // Stalled branch for three cycles, then release.
    for (int i = 0; i < 3; i++)
      cycle(32'h104, 1'b1, 1'b1, 1'b1, 32'h104, 32'h200, 1'b0, 32'h108, "stalled");
    cycle(32'h104, 1'b1, 1'b0, 1'b1, 32'h104, 32'h200, 1'b0, 32'h108, "released");
    lookup(32'h104, "after_release");

    // Not a branch: outcome ignored.
    cycle(32'h104, 1'b0, 1'b0, 1'b1, 32'h104, 32'h500, 1'b0, 32'h108, "not_branch");
    lookup(32'h104, "not_branch_after");

    // Random traffic over a few aliasing and distinct PCs.
    for (int n = 0; n < 150; n++) begin
      logic        ptk;
      logic [31:0] ppc, pce, tgt;
      pce = pcs[$urandom_range(0, 4)];
      tgt = {$urandom_range(0, 255), 2'b00} & 32'h3fc;
      model_pred(pce, ptk, ppc);
      if ($urandom_range(0, 7) == 0) ppc = ppc + 32'd16;
      cycle(pcs[$urandom_range(0, 4)], ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), pce, tgt, ptk, ppc, "rand");
    end

    // Make 0x104 strongly taken, then reset between edges mid-training.
    branch(32'h104, 1'b1, 32'h200, "pre_rst_a");
    branch(32'h104, 1'b1, 32'h200, "pre_rst_b");
    lookup(32'h104, "pre_rst_lookup");
    PCF = 32'h104; IsBranchE = 1'b1; StallE = 1'b0; BranchE = 1'b1; PCE = 32'h104;
    PCPlus4E = 32'h108; PCTargetE = 32'h300; PredTakenE = 1'b1; PredPCE = 32'h200;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    push(SIG_PTAKEN, "async_rst.ptaken", 32'h0);
    push(SIG_PPC, "async_rst.ppc", 32'h108);
    push(SIG_BCNT, "async_rst.bcnt", 32'h0);
    push(SIG_MCNT, "async_rst.mcnt", 32'h0);
    drain();
    @(posedge clk);
    @(negedge clk);
    IsBranchE = 1'b0;
    reset = 1'b1;
    lookup(32'h104, "after_async_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
